// File: rtl/word_to_byte_lane_pkg.sv
// Shared constants, state encoding and byte-select helper for the
// word-to-byte lane serializer.
package word_to_byte_lane_pkg;

  localparam logic [7:0]  IDLE_BYTE  = 8'hBC;  // K28.5 comma, sent between words
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;      // holds 0..FIFO_DEPTH

  typedef enum logic {
    ST_IDLE = 1'b0,  // no word loaded
    ST_SEND = 1'b1   // a word is loaded, byte_idx names the byte on data_out
  } lane_state_t;

  // Byte idx of a word, MSB first (idx 0 -> [31:24], idx 3 -> [7:0]).
  function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[WORD_W-1          -: BYTE_W];
      2'd1:    b = w[WORD_W-1-BYTE_W   -: BYTE_W];
      2'd2:    b = w[WORD_W-1-2*BYTE_W -: BYTE_W];
      default: b = w[BYTE_W-1:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word_to_byte_lane_fifo.sv
// fifo_palabras: two-entry word FIFO with count/full/empty, pointers wrap
// modulo 2. Push while full and pop while empty are ignored.
module fifo_palabras
  import word_to_byte_lane_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  // NOTE: the data array has no reset; count and pointers define validity, so
  // clearing it would only add reset fan-out.
  always_ff @(posedge clk_4f) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_to_byte_lane.sv
// word_to_byte_lane: buffers 32-bit lane words in a 2-entry FIFO and
// serializes them MSB byte first on a registered byte stream, sending
// IDLE_BYTE with valid_out low whenever no word is available.
module word_to_byte_lane
  import word_to_byte_lane_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = word_to_byte_lane_pkg::IDLE_BYTE
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              overflow
);

  lane_state_t       state, state_nxt;
  logic [1:0]        byte_idx, idx_nxt;
  logic [WORD_W-1:0] cur_word, word_nxt;
  logic [BYTE_W-1:0] data_nxt;
  logic              valid_nxt;

  logic              push;
  logic              pop;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Readiness comes from the pre-edge count, so a pop this cycle cannot reopen it.
  assign ready_out = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = valid_in && ready_out;

  fifo_palabras u_fifo (
    .clk_4f (clk_4f),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (data_in),
    .rdata  (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Serializer next state: at a word boundary load the FIFO head or go idle,
  // otherwise step to the next byte of the loaded word.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    idx_nxt   = byte_idx;
    word_nxt  = cur_word;
    data_nxt  = data_out;
    valid_nxt = valid_out;
    pop       = 1'b0;
    if (state == ST_IDLE || byte_idx == 2'd3) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        word_nxt  = fifo_head;
        data_nxt  = byte_of(fifo_head, 2'd0);
        valid_nxt = 1'b1;
        idx_nxt   = 2'd0;
        state_nxt = ST_SEND;
      end else begin
        data_nxt  = IDLE_BYTE;
        valid_nxt = 1'b0;
        idx_nxt   = 2'd0;
        state_nxt = ST_IDLE;
      end
    end else begin
      idx_nxt   = byte_idx + 2'd1;
      data_nxt  = byte_of(cur_word, byte_idx + 2'd1);
      valid_nxt = 1'b1;
    end
  end

  // Serializer registers; reset discards any partially sent word.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      byte_idx  <= 2'd0;
      cur_word  <= '0;
      data_out  <= IDLE_BYTE;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_idx  <= idx_nxt;
      cur_word  <= word_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
    end
  end

  // Sticky flag: a word offered while the FIFO was full is dropped.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (valid_in && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule
